shift_unit: RTL and testbench
=============================

# shift_unit

Parametrised multi-cycle shift/rotate unit for the CPU datapath. It is the successor to the single-cycle 32-bit `shra` path and supports configurable width, five shift modes, a configurable number of bits shifted per cycle, and a start/done handshake. Operand A comes from the Y register and the shift amount from the bus. The result feeds the Z-low register, and the control unit sequences the handshake.

## Interface
- `WIDTH`, 32: data width in bits; must be a power of two, ≥ 8.
- `STEP`, 1: maximum bits shifted per clock; power of two, 1 ≤ STEP ≤ WIDTH.
- `AMT_W`, $clog2(WIDTH): derived, not overridden.

Ports:
- `clock` input 1: single clock; everything updates on the rising edge.
- `clear` input 1: asynchronous, active-low reset.
- `start` input 1: request; sampled only while `busy`=0.
- `op` input 3: 000 shr, 001 shra, 010 shl, 011 ror, 100 rol; 101–111 reserved.
- `a` input WIDTH: operand to shift.
- `b` input WIDTH: shift amount; only `b[AMT_W-1:0]` is used.
- `result` output WIDTH: shifted value; holds until the next accepted `start`.
- `carry_out` output 1: last bit shifted or rotated out; 0 when the amount is 0.
- `busy` output 1: high in SHIFT and DONE.
- `done` output 1: one-cycle pulse; `result` and `carry_out` are valid from this cycle on.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE, `start`=1 at edge E0:
  - latch `a` into the working register, `n = b[AMT_W-1:0]` into `remaining`, and `op`;
  - clear `carry_out`;
  - go to SHIFT if n>0, else DONE.
- Reserved `op`: treated as n=0, so the result is `a` unchanged with `carry_out`=0.
- SHIFT, each edge:
  - shift by k = min(STEP, `remaining`); `remaining` -= k;
  - `carry_out` = last bit leaving the register on that step;
  - go to DONE when `remaining` becomes 0.
- Shift semantics:
  - shr fills with 0; shra fills with the sign bit; shl fills LSBs with 0;
  - ror/rol wrap the bits, and `carry_out` is the wrapped bit.
- DONE: `done`=1 for one cycle, then return to IDLE unconditionally.
- `start` while `busy`=1 is ignored, with no queuing.
- `start` in the same cycle DONE→IDLE is ignored; it is accepted on the following cycle.
- Masking: amounts ≥ WIDTH wrap modulo WIDTH. For example, b=33 with WIDTH=32 gives a shift of 1.

## Timing
- Reset (`clear`=0, asynchronous, any state): state IDLE, `result`=0, `carry_out`=0, `busy`=0, `done`=0, `remaining`=0.
- Reset mid-operation aborts the operation. No `done` is produced. Normal operation resumes on the first edge after `clear` returns high.
- Let m = ceil(n/STEP), with m=0 when n=0.
- `busy` rises after E0.
- `done` is high for exactly the cycle following edge E0+m. `busy` falls one cycle later.
- Back-to-back issue: the earliest next accepted `start` is at edge E0+m+2.
- `result` updates every SHIFT edge and is guaranteed only when `done`=1 or later.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Package `shift_pkg`:
  - op encodings as a 3-bit typedef with named constants;
  - state typedef (IDLE/SHIFT/DONE).
- Sub-module `shift_unit_step`: combinational single step.
  - Inputs: value, op, k (0..STEP).
  - Outputs: shifted value and out-bit.
  - Instantiated once in `shift_unit`.
- The top level holds the FSM, the working register, the `remaining` counter and the handshake.

## Test plan
1. WIDTH=32, STEP=1: shra, a=0xFFFFFFDE, b=2 → `done` 2 cycles after E0, `result`=0xFFFFFFF7, `carry_out`=1.
2. shr, a=0xFFFFFFDE, b=2 → `result`=0x3FFFFFF7, `carry_out`=1. Then rol, a=0x80000001, b=4 → `result`=0x00000018, `carry_out`=0.
3. STEP=4: shl, a=0x00000001, b=7 → `done` after 2 cycles (4+3), `result`=0x00000080. Also b=33 → treated as 1, `result`=0x00000002.
4. b=0 (any op) or op=101 → `done` in the cycle right after E0, `result`=`a`, `carry_out`=0.
5. `start` pulsed while `busy` during a b=5 shr → ignored; the first operation completes with the correct result. A second `start` at E0+m+2 is accepted.
6. `clear` driven low during SHIFT → immediately `busy`=0, `done`=0, `result`=0; no `done` pulse follows; a new `start` after release completes normally.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared types for the multi-cycle shift/rotate unit: op encodings and FSM states.
package shift_pkg;

  typedef logic [2:0] shift_op_t;

  localparam shift_op_t OP_SHR  = 3'b000;
  localparam shift_op_t OP_SHRA = 3'b001;
  localparam shift_op_t OP_SHL  = 3'b010;
  localparam shift_op_t OP_ROR  = 3'b011;
  localparam shift_op_t OP_ROL  = 3'b100;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Encodings above OP_ROL are reserved and behave as a zero-length shift.
  function automatic logic op_valid(input shift_op_t op);
    return (op <= OP_ROL);
  endfunction

endpackage

// File: rtl/shift_unit_if.sv
// Start/done handshake and operand/result bus between the control unit and the shift unit.
interface shift_unit_if
  import shift_pkg::*;
#(
  parameter int WIDTH = 32
);
  logic             start;
  shift_op_t        op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             busy;
  logic             done;

  modport master (
    output start, op, a, b,
    input  result, carry_out, busy, done
  );

  modport slave (
    input  start, op, a, b,
    output result, carry_out, busy, done
  );
endinterface

// File: rtl/shift_unit_step.sv
// Combinational single step: shifts/rotates a value by k bits (0..WIDTH) and reports the last bit out.
module shift_unit_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]         value,
  input  shift_op_t                op,
  input  logic [$clog2(WIDTH):0]   k,
  output logic [WIDTH-1:0]         shifted,
  output logic                     out_bit
);
  localparam int KW = $clog2(WIDTH) + 1;
  localparam logic [KW-1:0] WIDTH_K = KW'(WIDTH);

  logic [WIDTH:0]   right_ext;
  logic [WIDTH:0]   left_ext;
  logic [WIDTH-1:0] rot_r;
  logic [WIDTH-1:0] rot_l;

  // One guard bit on each side catches the last bit out without a variable index; it is 0 when k=0.
  assign right_ext = {value, 1'b0} >> k;
  assign left_ext  = {1'b0, value} << k;
  assign rot_r     = right_ext[WIDTH:1] | (value << (WIDTH_K - k));
  assign rot_l     = left_ext[WIDTH-1:0] | (value >> (WIDTH_K - k));

  always_comb begin
    shifted = value;
    out_bit = 1'b0;
    case (op)
      OP_SHR: begin
        shifted = right_ext[WIDTH:1];
        out_bit = right_ext[0];
      end
      OP_SHRA: begin
        shifted = $signed(value) >>> k;
        out_bit = right_ext[0];
      end
      OP_SHL: begin
        shifted = left_ext[WIDTH-1:0];
        out_bit = left_ext[WIDTH];
      end
      OP_ROR: begin
        shifted = rot_r;
        out_bit = right_ext[0];
      end
      OP_ROL: begin
        shifted = rot_l;
        out_bit = left_ext[WIDTH];
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/shift_unit.sv
// Multi-cycle shift/rotate unit: up to STEP bits per clock, start/done handshake, registered outputs.
//   state | meaning
//   IDLE  | waiting for start; result/carry_out hold the last answer
//   SHIFT | working register shifted by min(STEP, remaining) each edge
//   DONE  | done pulse for one cycle, then back to IDLE
module shift_unit
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic         clock,
  input  logic         clear,
  shift_unit_if.slave  bus
);
  localparam int AMT_W = $clog2(WIDTH);
  localparam int KW    = AMT_W + 1;
  localparam logic [KW-1:0] STEP_K = KW'(STEP);

  state_e           state, state_n;
  logic [WIDTH-1:0] work, work_n;
  logic             carry, carry_n;
  logic [AMT_W-1:0] remaining, remaining_n;
  shift_op_t        op_q, op_n;
  logic             busy_q, done_q;

  logic [KW-1:0]    rem_k;
  logic [KW-1:0]    k;
  logic [WIDTH-1:0] step_val;
  logic             step_bit;

  assign rem_k = {1'b0, remaining};
  assign k     = (rem_k < STEP_K) ? rem_k : STEP_K;

  shift_unit_step #(.WIDTH(WIDTH)) u_step (
    .value   (work),
    .op      (op_q),
    .k       (k),
    .shifted (step_val),
    .out_bit (step_bit)
  );

  always_comb begin
    state_n     = state;
    work_n      = work;
    carry_n     = carry;
    remaining_n = remaining;
    op_n        = op_q;
    case (state)
      IDLE: begin
        if (bus.start) begin
          work_n      = bus.a;
          op_n        = bus.op;
          carry_n     = 1'b0;
          remaining_n = op_valid(bus.op) ? bus.b[AMT_W-1:0] : '0;
          state_n     = (remaining_n != '0) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        work_n      = step_val;
        carry_n     = step_bit;
        remaining_n = AMT_W'(rem_k - k);
        if (remaining_n == '0) state_n = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // busy/done are flops fed from the next state so every output is registered.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state     <= IDLE;
      work      <= '0;
      carry     <= 1'b0;
      remaining <= '0;
      op_q      <= OP_SHR;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state     <= state_n;
      work      <= work_n;
      carry     <= carry_n;
      remaining <= remaining_n;
      op_q      <= op_n;
      busy_q    <= (state_n != IDLE);
      done_q    <= (state_n == DONE);
    end
  end

  assign bus.result    = work;
  assign bus.carry_out = carry;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
endmodule

// File: tb/tb_shift_unit.sv
// Scoreboard bench: STEP=1 and STEP=4 units driven side by side against an arithmetic reference model.
module tb_shift_unit;
  import shift_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic clr = 1'b0;
  always #5 clk = ~clk;

  shift_unit_if #(.WIDTH(W)) if1 ();
  shift_unit_if #(.WIDTH(W)) if4 ();

  shift_unit #(.WIDTH(W), .STEP(1)) dut1 (.clock(clk), .clear(clr), .bus(if1));
  shift_unit #(.WIDTH(W), .STEP(4)) dut4 (.clock(clk), .clear(clr), .bus(if4));

  typedef struct {
    logic [31:0] res;
    logic        carry;
    int          e0;
    int          m;
  } exp_t;

  exp_t q1[$];
  exp_t q4[$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;
  bit   pd1   = 1'b0;
  bit   pd4   = 1'b0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: direct arithmetic on the whole operand, amount taken modulo 32.
  function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] res, output logic c, output int n);
    n = int'(b % 32);
    if (op > 3'd4) n = 0;
    res = a;
    c   = 1'b0;
    if (n != 0) begin
      case (op)
        3'd0: begin res = a >> n;                      c = a[n-1];  end
        3'd1: begin res = $signed(a) >>> n;            c = a[n-1];  end
        3'd2: begin res = a << n;                      c = a[32-n]; end
        3'd3: begin res = (a >> n) | (a << (32 - n));  c = res[31]; end
        default: begin res = (a << n) | (a >> (32 - n)); c = res[0]; end
      endcase
    end
  endfunction

  task automatic push_exp(input int d, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int e0);
    exp_t e;
    int   n;
    int   step;
    step = (d == 0) ? 1 : 4;
    model(op, a, b, e.res, e.carry, n);
    e.e0 = e0;
    e.m  = (n + step - 1) / step;
    if (d == 0) q1.push_back(e);
    else        q4.push_back(e);
  endtask

  task automatic set_in(input int d, input logic s, input logic [2:0] op,
                        input logic [31:0] a, input logic [31:0] b);
    if (d == 0) begin
      if1.start = s; if1.op = op; if1.a = a; if1.b = b;
    end else begin
      if4.start = s; if4.op = op; if4.a = a; if4.b = b;
    end
  endtask

  function automatic logic dn(input int d);
    return (d == 0) ? if1.done : if4.done;
  endfunction

  task automatic check_pop(input int d, input logic [31:0] r, input logic c, input logic bsy);
    exp_t  e;
    string tag;
    tag = (d == 0) ? "s1" : "s4";
    if ((d == 0 && q1.size() == 0) || (d == 1 && q4.size() == 0)) begin
      chk({"spurious_done_", tag}, 64'd1, 64'd0);
      return;
    end
    e = (d == 0) ? q1.pop_front() : q4.pop_front();
    chk({"result_", tag}, {32'd0, r}, {32'd0, e.res});
    chk({"carry_", tag}, {63'd0, c}, {63'd0, e.carry});
    chk({"latency_", tag}, 64'(cyc - e.e0), 64'(e.m));
    chk({"busy_in_done_", tag}, {63'd0, bsy}, 64'd1);
  endtask

  always @(negedge clk) begin
    if (pd1) chk("after_done_s1", {62'd0, if1.busy, if1.done}, 64'd0);
    if (pd4) chk("after_done_s4", {62'd0, if4.busy, if4.done}, 64'd0);
    pd1 = if1.done;
    pd4 = if4.done;
    if (if1.done) check_pop(0, if1.result, if1.carry_out, if1.busy);
    if (if4.done) check_pop(1, if4.result, if4.carry_out, if4.busy);
  end

  task automatic wait_idle();
    for (int i = 0; i < 300 && (q1.size() != 0 || q4.size() != 0); i++) @(negedge clk);
    if (q1.size() != 0 || q4.size() != 0) begin
      chk("done_timeout", 64'(q1.size() + q4.size()), 64'd0);
      q1.delete();
      q4.delete();
    end
    @(negedge clk);
  endtask

  task automatic issue_both(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    set_in(0, 1'b1, op, a, b);
    set_in(1, 1'b1, op, a, b);
    push_exp(0, op, a, b, cyc + 1);
    push_exp(1, op, a, b, cyc + 1);
    @(negedge clk);
    set_in(0, 1'b0, op, a, b);
    set_in(1, 1'b0, op, a, b);
    wait_idle();
  endtask

  task automatic busy_ignore();
    @(negedge clk);
    set_in(0, 1'b1, OP_SHR, 32'hF0F0_1234, 32'd5);
    set_in(1, 1'b1, OP_SHR, 32'hF0F0_1234, 32'd5);
    push_exp(0, OP_SHR, 32'hF0F0_1234, 32'd5, cyc + 1);
    push_exp(1, OP_SHR, 32'hF0F0_1234, 32'd5, cyc + 1);
    @(negedge clk);
    chk("busy_high_s1", {63'd0, if1.busy}, 64'd1);
    chk("busy_high_s4", {63'd0, if4.busy}, 64'd1);
    set_in(0, 1'b1, OP_ROL, 32'hDEAD_BEEF, 32'd3);
    set_in(1, 1'b1, OP_ROL, 32'hDEAD_BEEF, 32'd3);
    @(negedge clk);
    set_in(0, 1'b0, OP_ROL, 32'hDEAD_BEEF, 32'd3);
    set_in(1, 1'b0, OP_ROL, 32'hDEAD_BEEF, 32'd3);
    wait_idle();
  endtask

  // Second start raised during the done cycle: ignored at E0+m+1, accepted at E0+m+2.
  task automatic back_to_back(input int d);
    bit seen;
    seen = 1'b0;
    @(negedge clk);
    set_in(d, 1'b1, OP_SHL, 32'h1, 32'd7);
    push_exp(d, OP_SHL, 32'h1, 32'd7, cyc + 1);
    @(negedge clk);
    set_in(d, 1'b0, OP_SHL, 32'h1, 32'd7);
    for (int i = 0; i < 100; i++) begin
      if (dn(d)) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!seen) chk("b2b_first_done", 64'd0, 64'd1);
    set_in(d, 1'b1, OP_ROR, 32'h1234_5678, 32'd6);
    push_exp(d, OP_ROR, 32'h1234_5678, 32'd6, cyc + 2);
    @(negedge clk);
    @(negedge clk);
    set_in(d, 1'b0, OP_ROR, 32'h1234_5678, 32'd6);
    wait_idle();
  endtask

  task automatic reset_mid();
    @(negedge clk);
    set_in(0, 1'b1, OP_SHR, 32'hFFFF_0000, 32'd20);
    set_in(1, 1'b1, OP_SHR, 32'hFFFF_0000, 32'd20);
    @(negedge clk);
    set_in(0, 1'b0, OP_SHR, 32'hFFFF_0000, 32'd20);
    set_in(1, 1'b0, OP_SHR, 32'hFFFF_0000, 32'd20);
    repeat (2) @(negedge clk);
    clr = 1'b0;
    #1;
    chk("rst_mid_busy_s1", {63'd0, if1.busy}, 64'd0);
    chk("rst_mid_done_s1", {63'd0, if1.done}, 64'd0);
    chk("rst_mid_result_s1", {32'd0, if1.result}, 64'd0);
    chk("rst_mid_busy_s4", {63'd0, if4.busy}, 64'd0);
    chk("rst_mid_done_s4", {63'd0, if4.done}, 64'd0);
    chk("rst_mid_result_s4", {32'd0, if4.result}, 64'd0);
    repeat (2) @(negedge clk);
    clr = 1'b1;
    repeat (25) @(negedge clk);
  endtask

  initial begin
    set_in(0, 1'b0, OP_SHR, 32'd0, 32'd0);
    set_in(1, 1'b0, OP_SHR, 32'd0, 32'd0);
    repeat (2) @(negedge clk);
    chk("rst_result_s1", {32'd0, if1.result}, 64'd0);
    chk("rst_carry_s1", {63'd0, if1.carry_out}, 64'd0);
    chk("rst_busy_s1", {63'd0, if1.busy}, 64'd0);
    chk("rst_done_s1", {63'd0, if1.done}, 64'd0);
    chk("rst_result_s4", {32'd0, if4.result}, 64'd0);
    chk("rst_carry_s4", {63'd0, if4.carry_out}, 64'd0);
    chk("rst_busy_s4", {63'd0, if4.busy}, 64'd0);
    chk("rst_done_s4", {63'd0, if4.done}, 64'd0);
    clr = 1'b1;

    issue_both(OP_SHRA, 32'hFFFF_FFDE, 32'd2);
    issue_both(OP_SHR,  32'hFFFF_FFDE, 32'd2);
    issue_both(OP_ROL,  32'h8000_0001, 32'd4);
    issue_both(OP_SHL,  32'h0000_0001, 32'd7);
    issue_both(OP_SHL,  32'h0000_0001, 32'd33);
    issue_both(OP_SHR,  32'h1234_5678, 32'd0);
    issue_both(3'b101,  32'hCAFE_BABE, 32'd9);
    issue_both(OP_SHRA, 32'h8000_0000, 32'd31);
    issue_both(OP_ROR,  32'h0000_0003, 32'd1);

    busy_ignore();
    back_to_back(0);
    back_to_back(1);
    reset_mid();
    issue_both(OP_SHL, 32'h0F0F_0F0F, 32'd13);

    for (int i = 0; i < 80; i++) begin
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 40));
      issue_both(op, a, b);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
